// File: rtl/membus_pkg.sv
// Shared widths and byte-lane helpers for the memory-bus arbiter.
package membus_pkg;

  localparam int unsigned MEMBUS_AW = 18;
  localparam int unsigned MEMBUS_DW = 32;

  // One-hot byte-lane select from the two low address bits.
  function automatic logic [3:0] lane_bytesel(input logic [1:0] lane);
    logic [3:0] sel;
    unique case (lane)
      2'd0: sel = 4'b0001;
      2'd1: sel = 4'b0010;
      2'd2: sel = 4'b0100;
      default: sel = 4'b1000;
    endcase
    return sel;
  endfunction

  function automatic logic [7:0] lane_extract(input logic [MEMBUS_DW-1:0] data,
                                              input logic [1:0] lane);
    logic [7:0] b;
    unique case (lane)
      2'd0: b = data[7:0];
      2'd1: b = data[15:8];
      2'd2: b = data[23:16];
      default: b = data[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/membus_arbiter_rr_arbiter.sv
// Combinational N-way round-robin arbiter; searches from ptr+1 upward, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic            valid
);

  logic [PtrW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = PtrW'((32'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// Memory-bus arbiter: CPU has zero-wait priority, renderer masters share the rest round-robin.
// Optional stall counter enabled by defining MEMBUS_STATS_EN.
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int unsigned NUM_BM     = 2,
  parameter int unsigned ADDR_WIDTH = MEMBUS_AW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        cpu_addr,
  input  logic [7:0]                   cpu_wrdata,
  input  logic                         cpu_strobe,
  input  logic                         cpu_write,
  output logic [7:0]                   cpu_rddata,
  input  logic [NUM_BM*ADDR_WIDTH-1:0] bm_addr,
  input  logic [NUM_BM-1:0]            bm_strobe,
  output logic [NUM_BM-1:0]            bm_ack,
  output logic [MEMBUS_DW-1:0]         bm_rddata,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [MEMBUS_DW-1:0]         mem_wrdata,
  output logic [3:0]                   mem_bytesel,
  output logic                         mem_strobe,
  output logic                         mem_write,
`ifdef MEMBUS_STATS_EN
  input  logic                         stats_clr,
  output logic [15:0]                  stall_count,
`endif
  input  logic [MEMBUS_DW-1:0]         mem_rddata
);

  localparam int unsigned PtrW = (NUM_BM > 1) ? $clog2(NUM_BM) : 1;
  localparam logic [PtrW-1:0] PtrRst = PtrW'(NUM_BM - 1);

  logic [NUM_BM-1:0] ack_q;
  logic [NUM_BM-1:0] eligible;
  logic [NUM_BM-1:0] arb_grant;
  logic              arb_valid;
  logic [NUM_BM-1:0] bm_grant;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   winner;
  logic [1:0]        cpu_lane_q, cpu_lane_d;

  // A master being acked this cycle still holds its strobe; skip it so it is not fetched twice.
  assign eligible = bm_strobe & ~ack_q;

  rr_arbiter #(
    .N    (NUM_BM),
    .PtrW (PtrW)
  ) u_rr_arbiter (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    bm_grant   = '0;
    winner     = '0;
    mem_addr   = '0;
    mem_strobe = 1'b0;
    mem_write  = 1'b0;
    ptr_d      = ptr_q;
    cpu_lane_d = cpu_lane_q;
    if (!rst) begin
      if (cpu_strobe) begin
        mem_addr   = cpu_addr;
        mem_strobe = 1'b1;
        mem_write  = cpu_write;
        if (!cpu_write) begin
          cpu_lane_d = cpu_addr[1:0];
        end
      end else if (arb_valid) begin
        bm_grant   = arb_grant;
        mem_strobe = 1'b1;
        for (int unsigned i = 0; i < NUM_BM; i++) begin
          if (arb_grant[i]) begin
            winner   = PtrW'(i);
            mem_addr = bm_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
        ptr_d = winner;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q      <= '0;
      ptr_q      <= PtrRst;
      cpu_lane_q <= 2'd0;
    end else begin
      ack_q      <= bm_grant;
      ptr_q      <= ptr_d;
      cpu_lane_q <= cpu_lane_d;
    end
  end

  assign bm_ack      = ack_q;
  assign bm_rddata   = mem_rddata;
  assign cpu_rddata  = lane_extract(mem_rddata, cpu_lane_q);
  assign mem_wrdata  = {4{cpu_wrdata}};
  assign mem_bytesel = lane_bytesel(mem_addr[1:0]);

`ifdef MEMBUS_STATS_EN
  logic [15:0] stall_q;
  logic        stall;

  // Counts cycles where some master wants the bus but none was granted, CPU cycles included.
  assign stall = (|bm_strobe) && (bm_grant == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else if (stats_clr) begin
      stall_q <= 16'd0;
    end else if (stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bm_ack));
  a_no_back_to_back: assert property (@(posedge clk) disable iff (rst) (bm_ack & bm_grant) == '0);

endmodule

// File: tb/tb_membus_arbiter.sv
// Randomized scoreboard bench for membus_arbiter; stats checks enabled with MEMBUS_STATS_EN.
module tb_membus_arbiter;

  localparam int N  = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wrdata = '0;
  logic          cpu_strobe = 1'b0;
  logic          cpu_write = 1'b0;
  logic [7:0]    cpu_rddata;
  logic [N*AW-1:0] bm_addr = '0;
  logic [N-1:0]  bm_strobe = '0;
  logic [N-1:0]  bm_ack;
  logic [31:0]   bm_rddata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wrdata;
  logic [3:0]    mem_bytesel;
  logic          mem_strobe;
  logic          mem_write;
  logic [31:0]   mem_rddata = '0;
  logic          clr_v = 1'b0;
`ifdef MEMBUS_STATS_EN
  logic [15:0]   stall_count;
`endif

  membus_arbiter #(
    .NUM_BM     (N),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_wrdata  (cpu_wrdata),
    .cpu_strobe  (cpu_strobe),
    .cpu_write   (cpu_write),
    .cpu_rddata  (cpu_rddata),
    .bm_addr     (bm_addr),
    .bm_strobe   (bm_strobe),
    .bm_ack      (bm_ack),
    .bm_rddata   (bm_rddata),
    .mem_addr    (mem_addr),
    .mem_wrdata  (mem_wrdata),
    .mem_bytesel (mem_bytesel),
    .mem_strobe  (mem_strobe),
    .mem_write   (mem_write),
`ifdef MEMBUS_STATS_EN
    .stats_clr   (clr_v),
    .stall_count (stall_count),
`endif
    .mem_rddata  (mem_rddata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          strobe;
    logic          write;
    logic [AW-1:0] addr;
    logic [3:0]    bsel;
    logic [31:0]   wdata;
  } mem_exp_t;
  typedef struct { int cyc; int idx; logic [31:0] data; } ack_exp_t;
  typedef struct { int cyc; logic [7:0] data; } cpu_exp_t;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];
  cpu_exp_t cpu_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;

  // Reference model state: last winner and the set of masters granted last cycle.
  int          last_w = N - 1;
  logic [N-1:0] acked_prev = '0;
  logic [15:0] stall_vis = 0;
  logic [15:0] stall_next = 0;
  logic [31:0] next_rd = 0;

  // Memory contents as seen by the bench: a fixed pattern with one pinned word.
  function automatic logic [31:0] ram_f(input logic [AW-1:0] a);
    if (a == 18'h20002) return 32'h44332211;
    return (32'(a) * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic do_cycle(input logic c_stb, input logic c_wr, input logic [AW-1:0] c_addr,
                          input logic [7:0] c_wd, input logic [N-1:0] b_stb,
                          input logic [N*AW-1:0] b_addr, input logic r);
    mem_exp_t     m;
    logic [N-1:0] g;
    @(negedge clk);
    cyc++;
    started    = 1;
    rst        = r;
    cpu_strobe = c_stb;
    cpu_write  = c_wr;
    cpu_addr   = c_addr;
    cpu_wrdata = c_wd;
    bm_strobe  = b_stb;
    bm_addr    = b_addr;
    g = '0;
    m = '{strobe: 1'b0, write: 1'b0, addr: '0, bsel: 4'b0001, wdata: '0};
    if (r) begin
      last_w     = N - 1;
      acked_prev = '0;
      while (ack_q.size() > 0 && ack_q[$].cyc == cyc) void'(ack_q.pop_back());
      while (cpu_q.size() > 0 && cpu_q[$].cyc == cyc) void'(cpu_q.pop_back());
      stall_vis  = 0;
      stall_next = 0;
    end else begin
      stall_vis = stall_next;
      if (c_stb) begin
        m = '{strobe: 1'b1, write: c_wr, addr: c_addr, bsel: 4'b0001 << c_addr[1:0],
              wdata: {4{c_wd}}};
        if (!c_wr) cpu_q.push_back('{cyc: cyc + 1, data: 8'(ram_f(c_addr) >> (8 * c_addr[1:0]))});
      end else begin
        for (int k = 1; k <= N; k++) begin
          int w;
          w = (last_w + k) % N;
          if (g == '0 && b_stb[w] && !acked_prev[w]) begin
            g[w] = 1'b1;
            last_w = w;
            m = '{strobe: 1'b1, write: 1'b0, addr: b_addr[w*AW +: AW],
                  bsel: 4'b0001 << b_addr[w*AW +: 2], wdata: '0};
            ack_q.push_back('{cyc: cyc + 1, idx: w, data: ram_f(b_addr[w*AW +: AW])});
          end
        end
      end
      if (clr_v) stall_next = 0;
      else if ((|b_stb) && g == '0 && stall_vis != 16'hFFFF) stall_next = stall_vis + 1;
      else stall_next = stall_vis;
      acked_prev = g;
    end
    mem_q.push_back(m);
  endtask

  // Monitor: runs mid-low-phase after the driver has applied this cycle's inputs.
  always @(negedge clk) begin
    #2;
    if (started) begin
      mem_exp_t e;
      ack_exp_t a;
      cpu_exp_t c;
      if (mem_q.size() == 0) begin
        chk("mem_q_underflow", 32'(mem_q.size()), 32'd1);
      end else begin
        e = mem_q.pop_front();
        chk("mem_strobe", 32'(mem_strobe), 32'(e.strobe));
        if (e.strobe) begin
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_write", 32'(mem_write), 32'(e.write));
          chk("mem_bytesel", 32'(mem_bytesel), 32'(e.bsel));
          if (e.write) chk("mem_wrdata", mem_wrdata, e.wdata);
        end
      end
      if (bm_ack != '0) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 32'(bm_ack), 32'd0);
        end else begin
          a = ack_q.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(a.cyc));
          chk("bm_ack", 32'(bm_ack), 32'(1) << a.idx);
          chk("bm_rddata", bm_rddata, a.data);
        end
      end else if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
        a = ack_q.pop_front();
        chk("missing_ack", 32'(bm_ack), 32'(1) << a.idx);
      end
      if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
        c = cpu_q.pop_front();
        chk("cpu_rddata", 32'(cpu_rddata), 32'(c.data));
      end
`ifdef MEMBUS_STATS_EN
      chk("stall_count", 32'(stall_count), 32'(stall_vis));
`endif
      next_rd = ram_f(mem_addr);
    end
  end

  always @(posedge clk) begin
    #1 mem_rddata = next_rd;
  end

  logic [N-1:0]  pend;
  logic [AW-1:0] paddr[N];
  logic [N*AW-1:0] baddr_v;

  initial begin
    for (int i = 0; i < N; i++) paddr[i] = AW'(18'h00100 + 18'(i * 4));
    pend = '0;
    baddr_v = {paddr[1], paddr[0]};
    // Reset held with both masters requesting: bus must stay idle.
    repeat (2) do_cycle(1'b0, 1'b0, '0, '0, 2'b11, baddr_v, 1'b1);
    // Both held: grants alternate 0,1,0,1.
    repeat (6) do_cycle(1'b0, 1'b0, '0, '0, 2'b11, baddr_v, 1'b0);
    repeat (2) do_cycle(1'b0, 1'b0, '0, '0, 2'b00, baddr_v, 1'b0);
    // CPU write preempts a requesting bm0.
    do_cycle(1'b1, 1'b1, 18'h00123, 8'hA5, 2'b01, baddr_v, 1'b0);
    repeat (6) do_cycle(1'b0, 1'b0, '0, '0, 2'b01, baddr_v, 1'b0);
    repeat (2) do_cycle(1'b0, 1'b0, '0, '0, 2'b00, baddr_v, 1'b0);
    // CPU read of lane 2.
    do_cycle(1'b1, 1'b0, 18'h20002, 8'h00, 2'b00, baddr_v, 1'b0);
    do_cycle(1'b0, 1'b0, '0, '0, 2'b00, baddr_v, 1'b0);

    for (int t = 0; t < 3000; t++) begin
      logic c_stb;
      logic r;
      for (int m = 0; m < N; m++) begin
        if (acked_prev[m]) pend[m] = ($urandom_range(3) != 0);
        else if (pend[m] && $urandom_range(15) == 0) pend[m] = 1'b0;
        else if (!pend[m]) pend[m] = ($urandom_range(1) == 1);
        if (acked_prev[m] || !pend[m]) paddr[m] = AW'($urandom);
      end
      baddr_v = {paddr[1], paddr[0]};
      c_stb = ($urandom_range(3) == 0);
      r = (t >= 1500 && t < 1502) || (t == 2400);
      do_cycle(c_stb, 1'($urandom), AW'($urandom), 8'($urandom), pend, baddr_v, r);
      if (r) pend = '0;
    end

`ifdef MEMBUS_STATS_EN
    clr_v = 1'b1;
    do_cycle(1'b0, 1'b0, '0, '0, 2'b00, baddr_v, 1'b0);
    clr_v = 1'b0;
    repeat (5) do_cycle(1'b1, 1'b1, 18'h00040, 8'h11, 2'b01, baddr_v, 1'b0);
    do_cycle(1'b0, 1'b0, '0, '0, 2'b00, baddr_v, 1'b0);
    chk("stall_five", 32'(stall_vis), 32'd5);
    clr_v = 1'b1;
    do_cycle(1'b0, 1'b0, '0, '0, 2'b00, baddr_v, 1'b0);
    clr_v = 1'b0;
    repeat (70000) do_cycle(1'b1, 1'b1, 18'h00040, 8'h11, 2'b01, baddr_v, 1'b0);
    do_cycle(1'b0, 1'b0, '0, '0, 2'b00, baddr_v, 1'b0);
    chk("stall_saturate", 32'(stall_vis), 32'h0000FFFF);
`endif

    repeat (4) do_cycle(1'b0, 1'b0, '0, '0, 2'b00, baddr_v, 1'b0);
    #5;
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
